// File: rtl/alu_arbiter_if.sv
// rtl/alu_arbiter_if.sv - Bus bundle between the ALU arbiter and its environment
//
// Groups the two requester command channels, the ALU operand/result path,
// the shared response channel and the debug counters.
//   slave  : arbiter side (consumes commands and ALU result, produces
//            ready, ALU operands, response and counters)
//   master : environment side (requesters, ALU and response consumer)
interface alu_arbiter_if #(
  parameter int WIDTH = 16,
  parameter int OPW   = 4,
  parameter int CNTW  = 16
);
  logic             r0_valid;
  logic             r0_ready;
  logic [OPW-1:0]   r0_op;
  logic [WIDTH-1:0] r0_a;
  logic [WIDTH-1:0] r0_b;
  logic             r1_valid;
  logic             r1_ready;
  logic [OPW-1:0]   r1_op;
  logic [WIDTH-1:0] r1_a;
  logic [WIDTH-1:0] r1_b;
  logic [OPW-1:0]   alu_op;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [WIDTH-1:0] alu_result;
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_err;
  logic             busy;
  logic [CNTW-1:0]  op_count;
  logic [CNTW-1:0]  err_count;

  modport slave (
    input  r0_valid, r0_op, r0_a, r0_b,
    input  r1_valid, r1_op, r1_a, r1_b,
    input  alu_result, rsp_ready,
    output r0_ready, r1_ready,
    output alu_op, alu_a, alu_b,
    output rsp_valid, rsp_id, rsp_data, rsp_err,
    output busy, op_count, err_count
  );

  modport master (
    output r0_valid, r0_op, r0_a, r0_b,
    output r1_valid, r1_op, r1_a, r1_b,
    output alu_result, rsp_ready,
    input  r0_ready, r1_ready,
    input  alu_op, alu_a, alu_b,
    input  rsp_valid, rsp_id, rsp_data, rsp_err,
    input  busy, op_count, err_count
  );
endinterface

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - Two-requester round-robin scheduler for a shared combinational ALU
//
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : alu_arbiter_if.slave
//          r0_*/r1_* command channels (valid/ready, op, a, b)
//          alu_op/alu_a/alu_b registered ALU operands, alu_result from the ALU
//          rsp_valid/rsp_ready/rsp_id/rsp_data/rsp_err shared response channel
//          busy, op_count, err_count debug status
//
// One command at a time: IDLE (grant) -> EXEC (ALU settles, capture) ->
// RESP (hold until consumed) -> IDLE.
module alu_arbiter #(
  parameter int WIDTH = 16,
  parameter int OPW   = 4,
  parameter int CNTW  = 16
) (
  input logic           clk,
  input logic           rst,
  alu_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  // Opcodes at or above this value hit the ALU's default case.
  localparam logic [OPW-1:0] ILLEGAL_MIN = OPW'(8);

  state_t           state;
  state_t           state_nx;
  logic             rr_ptr;
  logic             gnt0;
  logic             gnt1;

  logic [OPW-1:0]   op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             rsp_valid_q;
  logic             rsp_id_q;
  logic [WIDTH-1:0] rsp_data_q;
  logic             rsp_err_q;
  logic [CNTW-1:0]  op_cnt_q;
  logic [CNTW-1:0]  err_cnt_q;

  logic             rsp_fire;
  assign rsp_fire = rsp_valid_q & bus.rsp_ready;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (gnt0 || gnt1) state_nx = EXEC;
      EXEC:    state_nx = RESP;
      RESP:    if (rsp_fire) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Output logic: grant decode. r0 wins unless r1 is also valid and the
  // round-robin pointer favours r1.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state == IDLE) begin
      if (bus.r0_valid && (!bus.r1_valid || !rr_ptr)) begin
        gnt0 = 1'b1;
      end else if (bus.r1_valid) begin
        gnt1 = 1'b1;
      end
    end
  end

  // Datapath and bookkeeping registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr      <= 1'b0;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      op_cnt_q    <= '0;
      err_cnt_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt0) begin
            op_q     <= bus.r0_op;
            a_q      <= bus.r0_a;
            b_q      <= bus.r0_b;
            rsp_id_q <= 1'b0;
          end else if (gnt1) begin
            op_q     <= bus.r1_op;
            a_q      <= bus.r1_a;
            b_q      <= bus.r1_b;
            rsp_id_q <= 1'b1;
          end
        end
        EXEC: begin
          // ALU output is passed through untouched, including its
          // illegal-op marker; the error flag is derived from the opcode.
          rsp_data_q  <= bus.alu_result;
          rsp_err_q   <= (op_q >= ILLEGAL_MIN);
          rsp_valid_q <= 1'b1;
        end
        RESP: begin
          if (rsp_fire) begin
            rsp_valid_q <= 1'b0;
            rr_ptr      <= ~rsp_id_q;
            if (op_cnt_q != {CNTW{1'b1}}) begin
              op_cnt_q <= op_cnt_q + CNTW'(1);
            end
            if (rsp_err_q && (err_cnt_q != {CNTW{1'b1}})) begin
              err_cnt_q <= err_cnt_q + CNTW'(1);
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.r0_ready  = gnt0;
  assign bus.r1_ready  = gnt1;
  assign bus.alu_op    = op_q;
  assign bus.alu_a     = a_q;
  assign bus.alu_b     = b_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.busy      = (state != IDLE);
  assign bus.op_count  = op_cnt_q;
  assign bus.err_count = err_cnt_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - Directed table-driven bench for alu_arbiter
module tb_alu_arbiter;

  logic clk;
  logic rst;

  alu_arbiter_if #(.WIDTH(16), .OPW(4), .CNTW(16)) bus0 ();
  alu_arbiter_if #(.WIDTH(16), .OPW(4), .CNTW(2))  bus2 ();

  alu_arbiter #(.WIDTH(16), .OPW(4), .CNTW(16)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  alu_arbiter #(.WIDTH(16), .OPW(4), .CNTW(2)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference combinational ALU
  function automatic logic [15:0] alu_f(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return a << b[3:0];
      4'd6:    return a >> b[3:0];
      4'd7:    return a;
      default: return 16'hDEAD;
    endcase
  endfunction

  always_comb bus0.alu_result = alu_f(bus0.alu_op, bus0.alu_a, bus0.alu_b);
  always_comb bus2.alu_result = alu_f(bus2.alu_op, bus2.alu_a, bus2.alu_b);

  int total = 0;
  int bad   = 0;
  int exp_ops  = 0;
  int exp_errs = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rid;
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] data;
    logic        err;
  } vec_t;

  vec_t vecs[12];

  task automatic clear_inputs();
    bus0.r0_valid = 1'b0; bus0.r0_op = '0; bus0.r0_a = '0; bus0.r0_b = '0;
    bus0.r1_valid = 1'b0; bus0.r1_op = '0; bus0.r1_a = '0; bus0.r1_b = '0;
    bus0.rsp_ready = 1'b1;
    bus2.r0_valid = 1'b0; bus2.r0_op = '0; bus2.r0_a = '0; bus2.r0_b = '0;
    bus2.r1_valid = 1'b0; bus2.r1_op = '0; bus2.r1_a = '0; bus2.r1_b = '0;
    bus2.rsp_ready = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_inputs();
    @(negedge clk);
    rst = 1'b0;
    exp_ops  = 0;
    exp_errs = 0;
  endtask

  // Single command on dut0 with rsp_ready held high: ready in cycle 0,
  // response visible in cycle 2, counters updated after the handshake.
  task automatic run_cmd(input int idx, input vec_t v);
    string t;
    t = $sformatf("vec%0d", idx);
    @(negedge clk);
    bus0.rsp_ready = 1'b1;
    if (v.rid) begin
      bus0.r1_valid = 1'b1; bus0.r1_op = v.op; bus0.r1_a = v.a; bus0.r1_b = v.b;
    end else begin
      bus0.r0_valid = 1'b1; bus0.r0_op = v.op; bus0.r0_a = v.a; bus0.r0_b = v.b;
    end
    #1;
    chk({t, " ready"}, v.rid ? bus0.r1_ready : bus0.r0_ready, 1);
    @(negedge clk);
    bus0.r0_valid = 1'b0;
    bus0.r1_valid = 1'b0;
    chk({t, " exec_busy"}, bus0.busy, 1);
    chk({t, " exec_rsp_valid"}, bus0.rsp_valid, 0);
    @(negedge clk);
    chk({t, " rsp_valid"}, bus0.rsp_valid, 1);
    chk({t, " rsp_id"}, bus0.rsp_id, v.rid);
    chk({t, " rsp_data"}, bus0.rsp_data, v.data);
    chk({t, " rsp_err"}, bus0.rsp_err, v.err);
    @(negedge clk);
    exp_ops++;
    if (v.err) exp_errs++;
    chk({t, " idle_rsp_valid"}, bus0.rsp_valid, 0);
    chk({t, " op_count"}, bus0.op_count, exp_ops);
    chk({t, " err_count"}, bus0.err_count, exp_errs);
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();

    vecs[0]  = '{1'b0, 4'd0,  16'h0003, 16'h0004, 16'h0007, 1'b0};
    vecs[1]  = '{1'b1, 4'd9,  16'h0001, 16'h0001, 16'hDEAD, 1'b1};
    vecs[2]  = '{1'b0, 4'd1,  16'd10,   16'd3,    16'h0007, 1'b0};
    vecs[3]  = '{1'b1, 4'd2,  16'hFF0F, 16'h0F0F, 16'h0F0F, 1'b0};
    vecs[4]  = '{1'b0, 4'd3,  16'h00F0, 16'h0F00, 16'h0FF0, 1'b0};
    vecs[5]  = '{1'b1, 4'd4,  16'hFFFF, 16'h0F0F, 16'hF0F0, 1'b0};
    vecs[6]  = '{1'b0, 4'd5,  16'h0001, 16'h0004, 16'h0010, 1'b0};
    vecs[7]  = '{1'b1, 4'd6,  16'h8000, 16'h000F, 16'h0001, 1'b0};
    vecs[8]  = '{1'b0, 4'd0,  16'hFFFF, 16'h0001, 16'h0000, 1'b0};
    vecs[9]  = '{1'b1, 4'd15, 16'h1234, 16'h5678, 16'hDEAD, 1'b1};
    vecs[10] = '{1'b0, 4'd8,  16'h0002, 16'h0002, 16'hDEAD, 1'b1};
    vecs[11] = '{1'b1, 4'd7,  16'h1234, 16'h0000, 16'h1234, 1'b0};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst alu_op", bus0.alu_op, 0);
    chk("rst alu_a", bus0.alu_a, 0);
    chk("rst rsp_valid", bus0.rsp_valid, 0);
    chk("rst rsp_data", bus0.rsp_data, 0);
    chk("rst busy", bus0.busy, 0);
    chk("rst op_count", bus0.op_count, 0);
    chk("rst r0_ready", bus0.r0_ready, 0);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) run_cmd(i, vecs[i]);

    // Tie arbitration: r0, then r1, then r0 again
    do_reset();
    @(negedge clk);
    bus0.r0_valid = 1'b1; bus0.r0_op = 4'd1; bus0.r0_a = 16'd10;    bus0.r0_b = 16'd3;
    bus0.r1_valid = 1'b1; bus0.r1_op = 4'd2; bus0.r1_a = 16'hFF0F; bus0.r1_b = 16'h0F0F;
    #1;
    chk("tie1 r0_ready", bus0.r0_ready, 1);
    chk("tie1 r1_ready", bus0.r1_ready, 0);
    @(negedge clk);
    bus0.r0_valid = 1'b0;
    chk("tie1 exec r1_ready", bus0.r1_ready, 0);
    @(negedge clk);
    chk("tie1 rsp_data", bus0.rsp_data, 16'h0007);
    chk("tie1 rsp_id", bus0.rsp_id, 0);
    @(negedge clk);
    bus0.r0_valid = 1'b1;
    #1;
    chk("tie2 r1_ready", bus0.r1_ready, 1);
    chk("tie2 r0_ready", bus0.r0_ready, 0);
    @(negedge clk);
    bus0.r1_valid = 1'b0;
    @(negedge clk);
    chk("tie2 rsp_data", bus0.rsp_data, 16'h0F0F);
    chk("tie2 rsp_id", bus0.rsp_id, 1);
    @(negedge clk);
    bus0.r1_valid = 1'b1;
    #1;
    chk("tie3 r0_ready", bus0.r0_ready, 1);
    chk("tie3 r1_ready", bus0.r1_ready, 0);
    @(negedge clk);
    bus0.r0_valid = 1'b0;
    bus0.r1_valid = 1'b0;
    repeat (2) @(negedge clk);

    // Backpressure: r1 response stalled 5 cycles while r0 waits
    @(negedge clk);
    bus0.rsp_ready = 1'b0;
    bus0.r1_valid = 1'b1; bus0.r1_op = 4'd0; bus0.r1_a = 16'd1; bus0.r1_b = 16'd1;
    #1;
    chk("bp r1_ready", bus0.r1_ready, 1);
    @(negedge clk);
    bus0.r1_valid = 1'b0;
    bus0.r0_valid = 1'b1; bus0.r0_op = 4'd0; bus0.r0_a = 16'd5; bus0.r0_b = 16'd5;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp%0d rsp_valid", i), bus0.rsp_valid, 1);
      chk($sformatf("bp%0d rsp_data", i), bus0.rsp_data, 16'h0002);
      chk($sformatf("bp%0d rsp_id", i), bus0.rsp_id, 1);
      chk($sformatf("bp%0d busy", i), bus0.busy, 1);
      chk($sformatf("bp%0d r0_ready", i), bus0.r0_ready, 0);
      chk($sformatf("bp%0d r1_ready", i), bus0.r1_ready, 0);
      @(negedge clk);
    end
    bus0.rsp_ready = 1'b1;
    #1;
    chk("bp release r0_ready", bus0.r0_ready, 0);
    @(negedge clk);
    chk("bp after rsp_valid", bus0.rsp_valid, 0);
    chk("bp pending r0_ready", bus0.r0_ready, 1);
    @(negedge clk);
    bus0.r0_valid = 1'b0;
    @(negedge clk);
    chk("bp r0 rsp_data", bus0.rsp_data, 16'h000A);
    chk("bp r0 rsp_id", bus0.rsp_id, 0);
    @(negedge clk);

    // Reset during RESP (round-robin pointer currently favours r1)
    @(negedge clk);
    bus0.r0_valid = 1'b1; bus0.r0_op = 4'd0; bus0.r0_a = 16'h1111; bus0.r0_b = 16'h2222;
    @(negedge clk);
    bus0.r0_valid = 1'b0;
    bus0.rsp_ready = 1'b0;
    @(negedge clk);
    chk("rresp pre rsp_data", bus0.rsp_data, 16'h3333);
    rst = 1'b1;
    #1;
    chk("rresp rsp_valid", bus0.rsp_valid, 0);
    chk("rresp rsp_data", bus0.rsp_data, 0);
    chk("rresp alu_a", bus0.alu_a, 0);
    chk("rresp busy", bus0.busy, 0);
    chk("rresp op_count", bus0.op_count, 0);
    @(negedge clk);
    rst = 1'b0;
    bus0.rsp_ready = 1'b1;
    @(negedge clk);
    bus0.r0_valid = 1'b1; bus0.r0_op = 4'd3; bus0.r0_a = 16'h00AA; bus0.r0_b = 16'h0001;
    bus0.r1_valid = 1'b1; bus0.r1_op = 4'd4; bus0.r1_a = 16'h0055; bus0.r1_b = 16'h0001;
    #1;
    chk("post-rst tie r0_ready", bus0.r0_ready, 1);
    chk("post-rst tie r1_ready", bus0.r1_ready, 0);

    // Reset during EXEC
    @(negedge clk);
    bus0.r0_valid = 1'b0;
    bus0.r1_valid = 1'b0;
    chk("rexec pre alu_a", bus0.alu_a, 16'h00AA);
    rst = 1'b1;
    #1;
    chk("rexec alu_op", bus0.alu_op, 0);
    chk("rexec alu_a", bus0.alu_a, 0);
    chk("rexec alu_b", bus0.alu_b, 0);
    chk("rexec busy", bus0.busy, 0);
    chk("rexec rsp_valid", bus0.rsp_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rexec idle busy", bus0.busy, 0);

    // Counter saturation on the 2-bit instance
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      bus2.r0_valid = 1'b1; bus2.r0_op = 4'd9; bus2.r0_a = 16'd1; bus2.r0_b = 16'd1;
      #1;
      chk($sformatf("sat%0d ready", i), bus2.r0_ready, 1);
      @(negedge clk);
      bus2.r0_valid = 1'b0;
      repeat (2) @(negedge clk);
      chk($sformatf("sat%0d op_count", i), bus2.op_count, (i > 3) ? 3 : i);
      chk($sformatf("sat%0d err_count", i), bus2.err_count, (i > 3) ? 3 : i);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
